// File: rtl/qpu_exu_decode_q.sv
// qpu_exu_decode_q: queued decode stage with timepoint tagging and measurement-hazard stall
module qpu_exu_decode_q #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 4,
    parameter int TP_W    = 8,
    parameter int MEAS_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [INSTR_W-1:0]       i_instr,
    input  logic [PC_W-1:0]          i_pc,
    input  logic                     i_prdt_taken,
    input  logic                     flush,
    input  logic                     meas_done,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [INSTR_W-1:0]       o_instr,
    output logic [PC_W-1:0]          o_pc,
    output logic                     o_prdt_taken,
    output logic                     o_new_timepoint,
    output logic                     o_measure,
    output logic                     o_fmr,
    output logic [TP_W-1:0]          o_tp_id,
    output logic [MEAS_W-1:0]        o_meas_pending,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_meas_underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [DEPTH-1:0]   mem_pt;
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count;
    logic [TP_W-1:0]    tp;
    logic [MEAS_W-1:0]  pending;
    logic               underflow, enq, deq, blocked, meas_inc;

    assign o_instr      = mem_instr[rd_ptr];
    assign o_pc         = mem_pc[rd_ptr];
    assign o_prdt_taken = mem_pt[rd_ptr];

    assign o_measure       = o_instr[0] & (o_instr[9:1] == 9'h1FF);
    assign o_fmr           = ~o_instr[0] & (o_instr[4:1] == 4'b1110);
    assign o_new_timepoint = (~o_instr[0] & (o_instr[4:1] == 4'b1010)) | (o_instr[0] & (|o_instr[31:29]));
    assign o_tp_id         = tp + TP_W'(o_new_timepoint);

    assign blocked = (o_fmr & (pending != '0)) | (o_measure & (&pending));
    assign o_valid = (count != '0) & ~blocked & ~flush;
    assign i_ready = (count < (AW+1)'(DEPTH)) & ~flush;
    assign enq     = i_valid & i_ready;
    assign deq     = o_valid & o_ready;
    assign meas_inc = deq & o_measure;

    assign o_count          = count;
    assign o_meas_pending   = pending;
    assign o_meas_underflow = underflow;

    // circular buffer storage, pointers and occupancy; flush empties it without touching storage
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            mem_pt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                mem_instr[wr_ptr] <= i_instr;
                mem_pc[wr_ptr]    <= i_pc;
                mem_pt[wr_ptr]    <= i_prdt_taken;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            count <= (enq & ~deq) ? count + (AW+1)'(1) :
                     (deq & ~enq) ? count - (AW+1)'(1) : count;
        end
    end

    // outstanding-measurement counter; a return with nothing outstanding latches the error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            underflow <= 1'b0;
        end else if (meas_inc & ~meas_done) begin
            pending <= pending + MEAS_W'(1);
        end else if (meas_done & ~meas_inc) begin
            if (pending == '0)
                underflow <= 1'b1;
            else
                pending <= pending - MEAS_W'(1);
        end
    end

    // current timepoint advances when a timepoint-opening entry is dispatched
    always_ff @(posedge clk) begin
        if (rst)
            tp <= '0;
        else if (deq & o_new_timepoint)
            tp <= o_tp_id;
    end
endmodule

// File: tb/tb_qpu_exu_decode_q.sv
// tb_qpu_exu_decode_q: directed and randomized checks against a queue-based reference model
module tb_qpu_exu_decode_q;
    localparam int DEPTH = 4;
    localparam int TPW   = 2;
    localparam int MW    = 2;
    localparam int MAXM  = 3;

    logic        clk = 1'b0;
    logic        rst, i_valid, i_prdt_taken, flush, meas_done, o_ready;
    logic [31:0] i_instr, i_pc;
    logic        i_ready, o_valid, o_prdt_taken, o_new_timepoint, o_measure, o_fmr, o_meas_underflow;
    logic [31:0] o_instr, o_pc;
    logic [TPW-1:0] o_tp_id;
    logic [MW-1:0]  o_meas_pending;
    logic [2:0]     o_count;

    int n_checks = 0;
    int n_pass   = 0;

    qpu_exu_decode_q #(.INSTR_W(32), .PC_W(32), .DEPTH(DEPTH), .TP_W(TPW), .MEAS_W(MW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr), .i_pc(i_pc),
        .i_prdt_taken(i_prdt_taken), .flush(flush), .meas_done(meas_done), .o_valid(o_valid),
        .o_ready(o_ready), .o_instr(o_instr), .o_pc(o_pc), .o_prdt_taken(o_prdt_taken),
        .o_new_timepoint(o_new_timepoint), .o_measure(o_measure), .o_fmr(o_fmr), .o_tp_id(o_tp_id),
        .o_meas_pending(o_meas_pending), .o_count(o_count), .o_meas_underflow(o_meas_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    function automatic bit f_meas(input logic [31:0] x);
        return x[0] == 1'b1 && x[9:1] == 9'h1FF;
    endfunction
    function automatic bit f_fmr(input logic [31:0] x);
        return x[0] == 1'b0 && x[4:1] == 4'b1110;
    endfunction
    function automatic bit f_nt(input logic [31:0] x);
        return (x[0] == 1'b0 && x[4:1] == 4'b1010) || (x[0] == 1'b1 && x[31:29] != 3'd0);
    endfunction

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic pt; } ent_t;
    ent_t mq[$];
    ent_t h;
    int   m_tp = 0, m_pend = 0, cnt, etp;
    bit   m_uf = 0, hm, hf, hn, blk, ev, er, dq, eq, inc;

    // reference model: compare current outputs, then advance the model across the coming edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cnt = mq.size();
            hm = 0; hf = 0; hn = 0;
            if (cnt > 0) begin
                h  = mq[0];
                hm = f_meas(h.instr);
                hf = f_fmr(h.instr);
                hn = f_nt(h.instr);
            end
            blk = cnt > 0 && ((hf && m_pend != 0) || (hm && m_pend == MAXM));
            ev  = cnt > 0 && !blk && !flush;
            er  = cnt < DEPTH && !flush;
            etp = (m_tp + int'(hn)) % (1 << TPW);
            chk("m_o_valid", o_valid, ev);
            chk("m_i_ready", i_ready, er);
            chk("m_o_count", o_count, cnt);
            chk("m_pending", o_meas_pending, m_pend);
            chk("m_underflow", o_meas_underflow, m_uf);
            if (cnt > 0) begin
                chk("m_o_instr", o_instr, h.instr);
                chk("m_o_pc", o_pc, h.pc);
                chk("m_o_prdt", o_prdt_taken, h.pt);
                chk("m_o_measure", o_measure, hm);
                chk("m_o_fmr", o_fmr, hf);
                chk("m_o_new_tp", o_new_timepoint, hn);
                chk("m_o_tp_id", o_tp_id, etp);
            end
            if (rst) begin
                mq.delete();
                m_tp = 0; m_pend = 0; m_uf = 0;
            end else begin
                dq = ev && o_ready;
                eq = i_valid && er;
                if (flush) mq.delete();
                else begin
                    if (dq) void'(mq.pop_front());
                    if (eq) mq.push_back('{i_instr, i_pc, i_prdt_taken});
                end
                inc = dq && hm;
                if (inc && !meas_done) m_pend++;
                else if (meas_done && !inc) begin
                    if (m_pend == 0) m_uf = 1;
                    else m_pend--;
                end
                if (dq && hn) m_tp = etp;
            end
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic pt);
        i_valid = 1'b1; i_instr = ins; i_pc = pc; i_prdt_taken = pt;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic issue_chk(input string nm, input logic [31:0] pc, input int tpid, input bit nt);
        o_ready = 1'b1;
        #1;
        chk({nm, "_valid"}, o_valid, 1);
        chk({nm, "_pc"}, o_pc, pc);
        chk({nm, "_tp_id"}, o_tp_id, tpid);
        chk({nm, "_new_tp"}, o_new_timepoint, nt);
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    localparam logic [31:0] MEAS = 32'h3FF;
    localparam logic [31:0] FMR  = 32'h1C;
    localparam logic [31:0] QW   = 32'h14;

    initial begin
        rst = 1'b1; i_valid = 0; i_instr = 0; i_pc = 0; i_prdt_taken = 0;
        flush = 0; meas_done = 0; o_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_i_ready", i_ready, 1);
        chk("rst_o_count", o_count, 0);
        chk("rst_tp_id", o_tp_id, 0);
        chk("rst_pending", o_meas_pending, 0);
        chk("rst_o_instr", o_instr, 0);
        // fill and drain
        for (int k = 0; k < 4; k++) push(32'h100 * (k + 1), 32'h1000 + 4 * k, k[0]);
        #1;
        chk("fill_i_ready", i_ready, 0);
        chk("fill_count", o_count, 4);
        for (int k = 0; k < 4; k++) issue_chk("drain", 32'h1000 + 4 * k, 0, 0);
        #1;
        chk("drain_count", o_count, 0);
        // timepoints
        push(32'h1, 32'h2000, 0);
        push(32'h6000_0001, 32'h2004, 0);
        push(32'h1, 32'h2008, 0);
        push(QW, 32'h200C, 0);
        issue_chk("tp0", 32'h2000, 0, 0);
        issue_chk("tp1", 32'h2004, 1, 1);
        issue_chk("tp2", 32'h2008, 1, 0);
        issue_chk("tp3", 32'h200C, 2, 1);
        push(QW, 32'h2010, 0);
        push(QW, 32'h2014, 0);
        issue_chk("tp4", 32'h2010, 3, 1);
        issue_chk("tp_wrap", 32'h2014, 0, 1);
        // FMR hazard
        push(MEAS, 32'h3000, 0);
        push(MEAS, 32'h3004, 0);
        push(FMR, 32'h3008, 0);
        issue_chk("hz_m1", 32'h3000, 0, 0);
        issue_chk("hz_m2", 32'h3004, 0, 0);
        o_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            meas_done = (c == 2 || c == 6);
            #1;
            chk("hz_pending", o_meas_pending, c <= 2 ? 2 : c <= 6 ? 1 : 0);
            chk("hz_fmr_valid", o_valid, c >= 7);
            chk("hz_fmr_head", o_fmr, 1);
            @(negedge clk);
            meas_done = 1'b0;
        end
        o_ready = 1'b0;
        // saturation and simultaneity
        for (int k = 0; k < 4; k++) push(MEAS, 32'h4000 + 4 * k, 0);
        issue_chk("sat_m1", 32'h4000, 0, 0);
        issue_chk("sat_m2", 32'h4004, 0, 0);
        meas_done = 1'b1;
        issue_chk("sat_m3", 32'h4008, 0, 0);
        meas_done = 1'b0;
        #1;
        chk("sat_simul_pending", o_meas_pending, 2);
        issue_chk("sat_m4", 32'h400C, 0, 0);
        push(MEAS, 32'h4010, 0);
        #1;
        chk("sat_stall_valid", o_valid, 0);
        chk("sat_stall_pending", o_meas_pending, 3);
        o_ready = 1'b1; meas_done = 1'b1;
        #1;
        chk("sat_still_stalled", o_valid, 0);
        @(negedge clk);
        meas_done = 1'b0;
        #1;
        chk("sat_release_pending", o_meas_pending, 2);
        chk("sat_release_valid", o_valid, 1);
        @(negedge clk);
        o_ready = 1'b0;
        #1;
        chk("sat_reissue_pending", o_meas_pending, 3);
        meas_done = 1'b1;
        repeat (3) @(negedge clk);
        meas_done = 1'b0;
        #1;
        chk("sat_drain_pending", o_meas_pending, 0);
        chk("sat_no_uf", o_meas_underflow, 0);
        // underflow
        meas_done = 1'b1;
        @(negedge clk);
        meas_done = 1'b0;
        #1;
        chk("uf_pending", o_meas_pending, 0);
        chk("uf_flag", o_meas_underflow, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("uf_sticky", o_meas_underflow, 1);
        // flush and reset
        push(MEAS, 32'h5000, 0);
        issue_chk("fl_meas", 32'h5000, 0, 0);
        for (int k = 0; k < 3; k++) push(32'h200, 32'h5004 + 4 * k, 1);
        #1;
        chk("fl_count3", o_count, 3);
        flush = 1'b1; i_valid = 1'b1; i_instr = 32'h300; i_pc = 32'h5100;
        #1;
        chk("fl_i_ready", i_ready, 0);
        chk("fl_o_valid", o_valid, 0);
        @(negedge clk);
        flush = 1'b0; i_valid = 1'b0;
        #1;
        chk("fl_count", o_count, 0);
        chk("fl_valid_after", o_valid, 0);
        chk("fl_pending", o_meas_pending, 1);
        chk("fl_uf", o_meas_underflow, 1);
        @(negedge clk);
        #1;
        chk("fl_dropped", o_count, 0);
        push(QW, 32'h6000, 0);
        push(QW, 32'h6004, 0);
        rst = 1'b1; i_valid = 1'b1; i_instr = QW; o_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        #1;
        chk("rr_o_valid", o_valid, 0);
        chk("rr_i_ready", i_ready, 1);
        chk("rr_count", o_count, 0);
        chk("rr_tp_id", o_tp_id, 0);
        chk("rr_pending", o_meas_pending, 0);
        chk("rr_uf", o_meas_underflow, 0);
        chk("rr_o_instr", o_instr, 0);
        chk("rr_o_pc", o_pc, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            i_valid      = ($urandom_range(0, 2) != 0);
            o_ready      = ($urandom_range(0, 3) != 0);
            meas_done    = ($urandom_range(0, 4) == 0);
            i_pc         = $urandom;
            i_prdt_taken = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: i_instr = $urandom;
                1: i_instr = $urandom | 32'h1;
                2: i_instr = ($urandom & ~32'h3FF) | MEAS;
                3: i_instr = ($urandom & ~32'h1F) | QW;
                default: i_instr = ($urandom & ~32'h1F) | FMR;
            endcase
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; meas_done = 1'b0;
        repeat (3) @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
